// File: rtl/vending_pkg.sv
// Shared types and defaults for the keypad front end of the vending controller.
package vending_pkg;

  typedef enum logic [1:0] {
    ST_SCAN,
    ST_DEBOUNCE,
    ST_HOLD,
    ST_RELEASE
  } kp_state_t;

  typedef logic [3:0] key_code_t;

  localparam int DEF_SCAN_DIV     = 1000;
  localparam int DEF_DEBOUNCE_CNT = 4;
  localparam int DEF_REPEAT_TICKS = 250;

  // True when exactly one line of an active-low nibble is asserted.
  function automatic logic single_low(input logic [3:0] v);
    case (v)
      4'b1110, 4'b1101, 4'b1011, 4'b0111: return 1'b1;
      default:                            return 1'b0;
    endcase
  endfunction

  function automatic logic [1:0] low_idx(input logic [3:0] v);
    case (v)
      4'b1101: return 2'd1;
      4'b1011: return 2'd2;
      4'b0111: return 2'd3;
      default: return 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/keypad_scanner_if.sv
// Key delivery channel: valid/ready handshake carrying the accepted key code.
interface keypad_scanner_if;
  import vending_pkg::*;

  key_code_t key_code;
  logic      key_valid;
  logic      key_ready;

  modport master (output key_code, output key_valid, input key_ready);
  modport slave  (input key_code, input key_valid, output key_ready);
endinterface

// File: rtl/keypad_scan_tick.sv
// Scan-rate divider and 2-flop row synchronizer feeding the keypad FSM.
module keypad_scan_tick
  import vending_pkg::*;
#(
  parameter int SCAN_DIV = DEF_SCAN_DIV
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] i_row_n,
  output logic [3:0] o_row_sync,
  output logic       o_tick
);

  localparam int DW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(SCAN_DIV - 1);

  logic [DW-1:0] r_div;
  logic [3:0]    r_sync1, r_sync2;
  logic          w_wrap;

  assign w_wrap = (r_div == DIV_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_div   <= '0;
      r_sync1 <= 4'hF;
      r_sync2 <= 4'hF;
    end else begin
      r_div   <= w_wrap ? '0 : r_div + DW'(1);
      r_sync1 <= i_row_n;
      r_sync2 <= r_sync1;
    end
  end

  // Tick is high during the SCAN_DIV-th cycle after reset, consumed on its closing edge.
  assign o_tick     = w_wrap;
  assign o_row_sync = r_sync2;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 keypad scanner: column drive, debounce FSM and valid/ready key delivery.
// Optional auto-repeat while a key is held is enabled by defining KEYPAD_REPEAT_EN.
module keypad_scanner
  import vending_pkg::*;
#(
  parameter int SCAN_DIV     = DEF_SCAN_DIV,
  parameter int DEBOUNCE_CNT = DEF_DEBOUNCE_CNT
`ifdef KEYPAD_REPEAT_EN
  , parameter int REPEAT_TICKS = DEF_REPEAT_TICKS
`endif
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [3:0]              row_n,
  output logic [3:0]              col_n,
  keypad_scanner_if.master        kp
);

  localparam logic [3:0] CNT_LAST = 4'(DEBOUNCE_CNT - 1);
  localparam bit         DB_ONE   = (DEBOUNCE_CNT == 1);

  kp_state_t  r_state, w_state_nxt;
  logic [3:0] r_cnt, w_cnt_nxt;
  logic [3:0] r_pat, w_pat_nxt;
  logic [3:0] r_col_n;
  key_code_t  r_key_code;
  logic       r_key_valid;
  logic [3:0] w_row;
  logic       w_tick, w_adv, w_accept, w_hs;
  key_code_t  w_code;

`ifdef KEYPAD_REPEAT_EN
  localparam int RW = $clog2(REPEAT_TICKS + 1);
  localparam logic [RW-1:0] REP_LAST = RW'(REPEAT_TICKS - 1);
  logic [RW-1:0] r_rep, w_rep_nxt;
`endif

  keypad_scan_tick #(.SCAN_DIV(SCAN_DIV)) u_tick (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_row_n    (row_n),
    .o_row_sync (w_row),
    .o_tick     (w_tick)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_pat_nxt   = r_pat;
    w_adv       = 1'b0;
    w_accept    = 1'b0;
`ifdef KEYPAD_REPEAT_EN
    w_rep_nxt   = r_rep;
`endif
    if (w_tick) begin
      unique case (r_state)
        ST_SCAN: begin
          // Multi-row hits in one column are ambiguous and ignored.
          if (single_low(w_row)) begin
            w_pat_nxt = w_row;
            w_cnt_nxt = 4'd1;
            if (DB_ONE) begin
              w_accept    = 1'b1;
              w_state_nxt = ST_HOLD;
`ifdef KEYPAD_REPEAT_EN
              w_rep_nxt   = '0;
`endif
            end else begin
              w_state_nxt = ST_DEBOUNCE;
            end
          end else begin
            w_adv = 1'b1;
          end
        end
        ST_DEBOUNCE: begin
          if (w_row == r_pat) begin
            if (r_cnt == CNT_LAST) begin
              w_accept    = 1'b1;
              w_state_nxt = ST_HOLD;
`ifdef KEYPAD_REPEAT_EN
              w_rep_nxt   = '0;
`endif
            end else begin
              w_cnt_nxt = r_cnt + 4'd1;
            end
          end else begin
            w_adv       = 1'b1;
            w_state_nxt = ST_SCAN;
          end
        end
        ST_HOLD: begin
          if (&w_row) begin
            w_cnt_nxt = 4'd1;
            if (DB_ONE) begin
              w_adv       = 1'b1;
              w_state_nxt = ST_SCAN;
            end else begin
              w_state_nxt = ST_RELEASE;
            end
          end
`ifdef KEYPAD_REPEAT_EN
          else if (r_rep == REP_LAST) begin
            w_accept  = 1'b1;
            w_rep_nxt = '0;
          end else begin
            w_rep_nxt = r_rep + RW'(1);
          end
`endif
        end
        ST_RELEASE: begin
          if (&w_row) begin
            if (r_cnt == CNT_LAST) begin
              w_adv       = 1'b1;
              w_state_nxt = ST_SCAN;
            end else begin
              w_cnt_nxt = r_cnt + 4'd1;
            end
          end else begin
            w_state_nxt = ST_HOLD;
          end
        end
      endcase
    end
  end

  assign w_code = {low_idx(w_pat_nxt), low_idx(r_col_n)};
  assign w_hs   = r_key_valid & kp.key_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_SCAN;
      r_cnt   <= '0;
      r_pat   <= 4'hF;
      r_col_n <= 4'b1110;
`ifdef KEYPAD_REPEAT_EN
      r_rep   <= '0;
`endif
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_pat   <= w_pat_nxt;
      if (w_adv) r_col_n <= {r_col_n[2:0], r_col_n[3]};
`ifdef KEYPAD_REPEAT_EN
      r_rep   <= w_rep_nxt;
`endif
    end
  end

  // A new key is taken only into an empty slot or one being emptied this edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_key_code  <= '0;
      r_key_valid <= 1'b0;
    end else if (w_accept && (!r_key_valid || w_hs)) begin
      r_key_code  <= w_code;
      r_key_valid <= 1'b1;
    end else if (w_hs) begin
      r_key_valid <= 1'b0;
    end
  end

  assign col_n        = r_col_n;
  assign kp.key_code  = r_key_code;
  assign kp.key_valid = r_key_valid;

endmodule

// File: doc/keypad_scanner.md
KEYPAD_SCANNER -- requirements
Module: keypad_scanner

Interface
REQ-001 SCAN_DIV, 1000: clk cycles per scan tick; legal range 2..65535.
REQ-002 DEBOUNCE_CNT, 4: consecutive stable scan ticks required to accept a press or a release; legal range 1..15.
REQ-003 REPEAT_TICKS, 250: scan ticks between auto-repeat events; used only under KEYPAD_REPEAT_EN.
REQ-004 clk  input  1  single system clock; all logic rising-edge.
REQ-005 rst_n  input  1  asynchronous assert, active-low reset.
REQ-006 row_n  input  4  keypad rows; active-low, externally pulled up, asynchronous to clk.
REQ-007 col_n  output  4  keypad column drive; active-low, exactly one bit low at all times after reset.
REQ-008 key_code  output  4  accepted key, code = row_index*4 + col_index; feeds item_price of the display path.
REQ-009 key_valid  output  1  key_code holds a pending key.
REQ-010 key_ready  input  1  consumer accepts the key when key_valid and key_ready are both high on a rising edge.

Function
REQ-011 row_n SHALL pass through a 2-flop synchronizer; all decisions use the synchronized value.
REQ-012 A free-running divider SHALL assert a one-cycle scan tick every SCAN_DIV clk cycles.
REQ-013 FSM states: SCAN, DEBOUNCE, HOLD, RELEASE.
REQ-014 SCAN: on each tick, sample rows for the driven column; if exactly one row is low, capture row/column and go to DEBOUNCE with count=1; otherwise advance the column 0->1->2->3->0.
REQ-015 Two or more rows low in one column SHALL be treated as no key: no capture, column advances.
REQ-016 DEBOUNCE: the column SHALL stay fixed; on each tick, an identical row pattern increments the count and any difference returns to SCAN with the column advanced.
REQ-017 When the count reaches DEBOUNCE_CNT, the key SHALL be accepted, and the FSM SHALL move to HOLD.
REQ-018 An accepted key with key_valid low SHALL load key_code and set key_valid on the next edge.
REQ-019 An accepted key with key_valid already high SHALL be dropped; the pending key_code SHALL NOT change.
REQ-020 key_valid and key_code SHALL stay stable until the handshake edge; key_valid clears on that edge.
REQ-021 HOLD: the column stays fixed; the first tick with all rows high goes to RELEASE with count=1.
REQ-022 RELEASE: each all-high tick increments the count; any low row returns to HOLD.
REQ-023 RELEASE: at count DEBOUNCE_CNT, the FSM SHALL go to SCAN with the column advanced.
REQ-024 A handshake and a new acceptance in the same cycle SHALL leave key_valid high with the new key_code.
REQ-025 Acceptance-to-key_valid latency SHALL be 1 clk.
REQ-026 Worst-case press-to-key_valid latency SHALL be (4+DEBOUNCE_CNT)*SCAN_DIV + 3 clk.

Reset
REQ-027 On rst_n low: FSM=SCAN, col_n=4'b1110, key_code=0, key_valid=0, divider=0, counters=0, synchronizer=4'b1111.
REQ-028 Reset asserted mid-debounce or mid-hold SHALL discard the press with no key_valid pulse.
REQ-029 The first scan tick after reset release SHALL occur SCAN_DIV cycles later.

Configuration
REQ-030 With KEYPAD_REPEAT_EN defined, HOLD SHALL re-accept the held key every REPEAT_TICKS ticks, under the same rules as REQ-018..REQ-019.
REQ-031 Without KEYPAD_REPEAT_EN, one press SHALL yield exactly one acceptance, and no repeat counter SHALL be synthesized.

Structure
REQ-032 Package vending_pkg SHALL hold the FSM state enum, the key_code_t (4-bit) typedef and the default SCAN_DIV/DEBOUNCE_CNT constants.
REQ-033 The tick divider plus synchronizer SHALL be sub-module keypad_scan_tick; the FSM and handshake stay in keypad_scanner.

Verification (SCAN_DIV=4, DEBOUNCE_CNT=3, REPEAT_TICKS=5)
REQ-034 Hold row 2 low while column 1 is driven, key_ready=1 -> key_valid for 1 clk with key_code=9, within 4*7+3 clk.
REQ-035 Bounce row 0 for 2 ticks, then release -> no key_valid; col_n resumes cycling 1110,1101,1011,0111.
REQ-036 Press key 5, key_ready=0 -> key_valid held with key_code=5.
REQ-036 (cont.) Release and press key 3 -> key_code stays 5; key_ready=1 -> clears next edge.
REQ-037 Rows 0 and 3 low together in one column -> no key_valid, scanning continues.
REQ-038 Assert rst_n low during DEBOUNCE -> col_n=1110, key_valid=0 and no later spurious key.
REQ-039 KEYPAD_REPEAT_EN defined, hold key 7 for 20 ticks, key_ready=1 -> initial key_valid plus one every 5 ticks, key_code=7.
REQ-039 (cont.) Same test without the macro -> exactly one pulse.
